// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: default sizes and FSM state encodings.
package dmem_responder_pkg;

  localparam int DMEM_DEPTH  = 4;
  localparam int DMEM_ADDR_W = 12;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_responder_store_buffer.sv
// Posted-write FIFO with a combinational youngest-first address lookup.
// Push and pop take effect at the clock edge; the caller keeps push low when full.
module store_buffer #(
  parameter int  DEPTH  = 4,
  parameter int  ADDR_W = 12,
  parameter int  DATA_W = 32,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [ADDR_W-1:0] push_addr_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W-1:0] head_addr_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic              hit_o,
  output logic [DATA_W-1:0] hit_data_o
);

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  scan_idx;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    valid_d = valid_q;
    if (pop_i) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + PTR_W'(1);
    end
    if (push_i) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_i) - CNT_W'(pop_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      addr_q[tail_q] <= push_addr_i;
      data_q[tail_q] <= push_data_i;
    end
  end

  // Scan oldest to youngest so the last match found is the youngest store.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    scan_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head_q + PTR_W'(i);
      if (valid_q[scan_idx] && (addr_q[scan_idx] == lookup_addr_i)) begin
        hit_o      = 1'b1;
        hit_data_o = data_q[scan_idx];
      end
    end
  end

  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign head_addr_o = addr_q[head_q];
  assign head_data_o = data_q[head_q];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: posted stores drain to backing RAM, loads forward from the buffer or miss to RAM.
// Load hits return one cycle later; stall is raised while the buffer is full or a load miss is outstanding.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  input  logic [ADDR_W-1:0] address_dmem,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  input  logic              rden,
  output logic [DATA_W-1:0] q_dmem,
  output logic              q_valid,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  dmem_state_e       state_q, state_d;
  logic [DATA_W-1:0] q_dmem_q, q_dmem_d;
  logic              q_valid_q, q_valid_d;
  logic              rd_done_q, rd_done_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              sb_full, sb_empty, sb_hit;
  logic [ADDR_W-1:0] sb_head_addr;
  logic [DATA_W-1:0] sb_head_data, sb_hit_data;
  logic              load_req, miss_pend, push, pop;

  // A simultaneous wren+rden is treated as a store only.
  assign load_req  = rden && !wren;
  assign miss_pend = load_req && !sb_hit && !rd_done_q;
  assign push      = wren && !sb_full;
  assign pop       = (state_q == WR_WAIT) && mem_ack;
  assign stall     = !ctrl_reset && ((wren && sb_full) || miss_pend);

  store_buffer #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_sb (
    .clk_i        (clock),
    .rst_i        (ctrl_reset),
    .push_i       (push),
    .push_addr_i  (address_dmem),
    .push_data_i  (data),
    .pop_i        (pop),
    .lookup_addr_i(address_dmem),
    .full_o       (sb_full),
    .empty_o      (sb_empty),
    .head_addr_o  (sb_head_addr),
    .head_data_o  (sb_head_data),
    .hit_o        (sb_hit),
    .hit_data_o   (sb_hit_data)
  );

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_q     <= IDLE;
      q_dmem_q    <= '0;
      q_valid_q   <= 1'b0;
      rd_done_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      q_dmem_q    <= q_dmem_d;
      q_valid_q   <= q_valid_d;
      rd_done_q   <= rd_done_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Read misses beat drains in IDLE since the pipeline is frozen on them.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (miss_pend)      state_d = RD_WAIT;
        else if (!sb_empty) state_d = WR_WAIT;
      end
      RD_WAIT: if (mem_ack) state_d = IDLE;
      WR_WAIT: if (mem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    q_dmem_d    = load_req && sb_hit ? sb_hit_data : q_dmem_q;
    q_valid_d   = load_req && sb_hit && !rd_done_q;
    rd_done_d   = 1'b0;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (miss_pend) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = address_dmem;
        end else if (!sb_empty) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = sb_head_addr;
          mem_wdata_d = sb_head_data;
        end
      end
      RD_WAIT: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          q_dmem_d  = mem_rdata;
          q_valid_d = 1'b1;
          rd_done_d = 1'b1;
        end
      end
      WR_WAIT: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign q_dmem    = q_dmem_q;
  assign q_valid   = q_valid_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a behavioural backing RAM that acks after a programmable delay.
module tb_dmem_responder;

  logic        clock = 1'b0;
  logic        ctrl_reset;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren, rden;
  logic [31:0] q_dmem;
  logic        q_valid, stall;
  logic        mem_req, mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack   = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        we;
    logic [11:0] a;
    logic [31:0] d;
  } txn_t;

  txn_t        log_q[$];
  logic [31:0] backing [0:4095];
  int          ack_delay = 1;
  bit          ack_en    = 1'b1;
  int          req_cnt   = 0;

  always #5 clock = ~clock;

  dmem_responder dut (
    .clock       (clock),
    .ctrl_reset  (ctrl_reset),
    .address_dmem(address_dmem),
    .data        (data),
    .wren        (wren),
    .rden        (rden),
    .q_dmem      (q_dmem),
    .q_valid     (q_valid),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  // Backing RAM: counts request cycles and pulses ack for one cycle once the delay is reached.
  always @(posedge clock) begin
    #1;
    if (ctrl_reset || !mem_req || mem_ack) begin
      mem_ack = 1'b0;
      req_cnt = 0;
    end else begin
      req_cnt++;
      if (ack_en && req_cnt >= ack_delay) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          backing[mem_addr] = mem_wdata;
          log_q.push_back('{we: 1'b1, a: mem_addr, d: mem_wdata});
        end else begin
          mem_rdata = backing[mem_addr];
          log_q.push_back('{we: 1'b0, a: mem_addr, d: backing[mem_addr]});
        end
      end
    end
  end

  task automatic drive(input logic w, input logic r, input logic [11:0] a, input logic [31:0] d);
    @(negedge clock);
    wren = w;
    rden = r;
    address_dmem = a;
    data = d;
    #1;
  endtask

  task automatic wait_drained(input int max_cycles, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clock);
      #1;
      if (dut.u_sb.count_q == 3'd0 && !mem_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_stall_low(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (!stall) break;
      @(negedge clock);
      #1;
    end
  endtask

  task automatic test_reset();
    ctrl_reset = 1'b1;
    wren = 1'b0;
    rden = 1'b1;
    address_dmem = 12'd5;
    data = '0;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if ({q_valid, mem_req, mem_we, stall} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl got={q_valid,mem_req,mem_we,stall}=%b want=0000", {q_valid, mem_req, mem_we, stall});
    end
    checks++;
    if (q_dmem !== 32'h0 || mem_addr !== 12'h0 || mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got q=%h addr=%h wdata=%h want all zero", q_dmem, mem_addr, mem_wdata);
    end
    checks++;
    if (dut.u_sb.count_q !== 3'd0) begin
      failures++;
      $display("FAIL reset_count got=%0d want=0", dut.u_sb.count_q);
    end
    @(negedge clock);
    rden = 1'b0;
    ctrl_reset = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    log_q.delete();
    ack_en = 1'b1;
    ack_delay = 3;
    drive(1'b1, 1'b0, 12'd3, 32'h5);
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL rst_drain_store_stall got=%b want=0", stall);
    end
    drive(1'b0, 1'b0, 12'd0, 32'h0);
    @(negedge clock);
    #1;
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b1, 12'd3}) begin
      failures++;
      $display("FAIL rst_drain_inflight got req=%b we=%b addr=%h want 1 1 003", mem_req, mem_we, mem_addr);
    end
    ctrl_reset = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || dut.u_sb.count_q !== 3'd0) begin
      failures++;
      $display("FAIL rst_drain_clear got req=%b count=%0d want 0 0", mem_req, dut.u_sb.count_q);
    end
    @(negedge clock);
    @(negedge clock);
    ctrl_reset = 1'b0;
    drive(1'b0, 1'b1, 12'd3, 32'h0);
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL rst_drain_load_miss got stall=%b want=1", stall);
    end
    wait_stall_low(30);
    checks++;
    if (stall !== 1'b0 || q_valid !== 1'b1 || q_dmem !== 32'hC0DE_0003) begin
      failures++;
      $display("FAIL rst_drain_load_data got stall=%b qv=%b q=%h want 0 1 c0de0003", stall, q_valid, q_dmem);
    end
    drive(1'b0, 1'b0, 12'd0, 32'h0);
    checks++;
    if (log_q.size() != 1 || log_q[0].we !== 1'b0 || log_q[0].a !== 12'd3) begin
      failures++;
      $display("FAIL rst_drain_log got size=%0d want one read of addr 3", log_q.size());
    end
  endtask

  task automatic test_load_miss();
    log_q.delete();
    ack_en = 1'b1;
    ack_delay = 3;
    backing[20] = 32'h1234;
    drive(1'b0, 1'b1, 12'd20, 32'h0);
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL miss_stall_c0 got=%b want=1", stall);
    end
    for (int k = 1; k < 4; k++) begin
      @(negedge clock);
      #1;
      checks++;
      if (stall !== 1'b1) begin
        failures++;
        $display("FAIL miss_stall_c%0d got=%b want=1", k, stall);
      end
    end
    @(negedge clock);
    #1;
    checks++;
    if (stall !== 1'b0 || q_valid !== 1'b1 || q_dmem !== 32'h1234) begin
      failures++;
      $display("FAIL miss_result got stall=%b qv=%b q=%h want 0 1 00001234", stall, q_valid, q_dmem);
    end
    drive(1'b0, 1'b0, 12'd0, 32'h0);
    checks++;
    if (q_valid !== 1'b0) begin
      failures++;
      $display("FAIL miss_qvalid_drop got=%b want=0", q_valid);
    end
    checks++;
    if (log_q.size() != 1 || log_q[0].we !== 1'b0 || log_q[0].a !== 12'd20) begin
      failures++;
      $display("FAIL miss_one_read got size=%0d want one read of addr 20", log_q.size());
    end
  endtask

  task automatic test_forwarding();
    bit ok;
    log_q.delete();
    ack_en = 1'b0;
    drive(1'b1, 1'b0, 12'd7, 32'hAAAA);
    drive(1'b1, 1'b0, 12'd7, 32'hBBBB);
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL fwd_store_stall got=%b want=0", stall);
    end
    drive(1'b0, 1'b1, 12'd7, 32'h0);
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL fwd_load_stall got=%b want=0", stall);
    end
    drive(1'b0, 1'b0, 12'd0, 32'h0);
    checks++;
    if (q_valid !== 1'b1 || q_dmem !== 32'hBBBB) begin
      failures++;
      $display("FAIL fwd_youngest got qv=%b q=%h want 1 0000bbbb", q_valid, q_dmem);
    end
    checks++;
    if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b1, 12'd7}) begin
      failures++;
      $display("FAIL fwd_no_read got req=%b we=%b addr=%h want 1 1 007", mem_req, mem_we, mem_addr);
    end
    drive(1'b0, 1'b0, 12'd0, 32'h0);
    checks++;
    if (q_valid !== 1'b0) begin
      failures++;
      $display("FAIL fwd_qvalid_drop got=%b want=0", q_valid);
    end
    ack_en = 1'b1;
    ack_delay = 1;
    wait_drained(40, ok);
    checks++;
    if (!ok || log_q.size() != 2 || log_q[0] !== {1'b1, 12'd7, 32'hAAAA} || log_q[1] !== {1'b1, 12'd7, 32'hBBBB}) begin
      failures++;
      $display("FAIL fwd_no_merge got drained=%b size=%0d want two writes to addr 7 aaaa,bbbb", ok, log_q.size());
    end
  endtask

  task automatic test_full_buffer();
    bit ok;
    log_q.delete();
    ack_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 12'(i), 32'h100 + 32'(i));
      checks++;
      if (stall !== 1'b0) begin
        failures++;
        $display("FAIL full_store%0d_stall got=%b want=0", i, stall);
      end
    end
    drive(1'b1, 1'b0, 12'd4, 32'h104);
    checks++;
    if (stall !== 1'b1) begin
      failures++;
      $display("FAIL full_fifth_stall got=%b want=1", stall);
    end
    ack_en = 1'b1;
    ack_delay = 1;
    drive(1'b1, 1'b0, 12'd4, 32'h104);
    ack_en = 1'b0;
    checks++;
    if (mem_ack !== 1'b1 || stall !== 1'b1) begin
      failures++;
      $display("FAIL full_ack_cycle got ack=%b stall=%b want 1 1", mem_ack, stall);
    end
    drive(1'b1, 1'b0, 12'd4, 32'h104);
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL full_after_pop got stall=%b want=0", stall);
    end
    drive(1'b0, 1'b0, 12'd0, 32'h0);
    ack_en = 1'b1;
    wait_drained(80, ok);
    checks++;
    if (!ok || log_q.size() != 5) begin
      failures++;
      $display("FAIL full_drain got drained=%b size=%0d want 1 5", ok, log_q.size());
    end
    for (int i = 0; i < 5 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== {1'b1, 12'(i), 32'h100 + 32'(i)}) begin
        failures++;
        $display("FAIL full_order%0d got we=%b addr=%h data=%h want 1 %h %h",
                 i, log_q[i].we, log_q[i].a, log_q[i].d, 12'(i), 32'h100 + 32'(i));
      end
    end
  endtask

  task automatic test_read_priority();
    bit ok;
    logic [12:0] exp_wa [4];
    log_q.delete();
    ack_en = 1'b1;
    ack_delay = 3;
    exp_wa[0] = {1'b1, 12'd30};
    exp_wa[1] = {1'b0, 12'd9};
    exp_wa[2] = {1'b1, 12'd31};
    exp_wa[3] = {1'b1, 12'd32};
    drive(1'b1, 1'b0, 12'd30, 32'h30);
    drive(1'b1, 1'b0, 12'd31, 32'h31);
    drive(1'b1, 1'b0, 12'd32, 32'h32);
    drive(1'b0, 1'b1, 12'd9, 32'h0);
    checks++;
    if ({stall, mem_req, mem_we, mem_addr} !== {1'b1, 1'b1, 1'b1, 12'd30}) begin
      failures++;
      $display("FAIL prio_setup got stall=%b req=%b we=%b addr=%h want 1 1 1 01e", stall, mem_req, mem_we, mem_addr);
    end
    wait_stall_low(60);
    checks++;
    if (stall !== 1'b0 || q_valid !== 1'b1 || q_dmem !== 32'hC0DE_0009) begin
      failures++;
      $display("FAIL prio_load got stall=%b qv=%b q=%h want 0 1 c0de0009", stall, q_valid, q_dmem);
    end
    drive(1'b0, 1'b0, 12'd0, 32'h0);
    wait_drained(80, ok);
    checks++;
    if (!ok || log_q.size() != 4) begin
      failures++;
      $display("FAIL prio_drain got drained=%b size=%0d want 1 4", ok, log_q.size());
    end
    for (int i = 0; i < 4 && i < log_q.size(); i++) begin
      checks++;
      if ({log_q[i].we, log_q[i].a} !== exp_wa[i]) begin
        failures++;
        $display("FAIL prio_order%0d got we=%b addr=%h want we=%b addr=%h",
                 i, log_q[i].we, log_q[i].a, exp_wa[i][12], exp_wa[i][11:0]);
      end
    end
  endtask

  task automatic test_pointer_wrap();
    bit ok;
    log_q.delete();
    ack_en = 1'b1;
    ack_delay = 1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b0, 12'd50 + 12'(i), 32'h5000 + 32'(i));
      drive(1'b0, 1'b0, 12'd0, 32'h0);
      wait_drained(20, ok);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL wrap_drain%0d got count=%0d req=%b want 0 0", i, dut.u_sb.count_q, mem_req);
      end
    end
    checks++;
    if (log_q.size() != 10 || dut.u_sb.count_q !== 3'd0) begin
      failures++;
      $display("FAIL wrap_total got size=%0d count=%0d want 10 0", log_q.size(), dut.u_sb.count_q);
    end
    for (int i = 0; i < 10 && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== {1'b1, 12'd50 + 12'(i), 32'h5000 + 32'(i)}) begin
        failures++;
        $display("FAIL wrap_entry%0d got we=%b addr=%h data=%h", i, log_q[i].we, log_q[i].a, log_q[i].d);
      end
    end
  endtask

  task automatic test_store_with_load();
    bit ok;
    log_q.delete();
    ack_en = 1'b1;
    ack_delay = 1;
    $display("note: driving illegal wren+rden together, expecting store only");
    drive(1'b1, 1'b1, 12'd60, 32'h6060);
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL illegal_stall got=%b want=0", stall);
    end
    drive(1'b0, 1'b0, 12'd0, 32'h0);
    checks++;
    if (q_valid !== 1'b0) begin
      failures++;
      $display("FAIL illegal_qvalid got=%b want=0", q_valid);
    end
    wait_drained(20, ok);
    checks++;
    if (!ok || log_q.size() != 1 || log_q[0] !== {1'b1, 12'd60, 32'h6060}) begin
      failures++;
      $display("FAIL illegal_store_only got drained=%b size=%0d want one write 060/6060", ok, log_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 4096; a++) backing[a] = 32'hC0DE_0000 + 32'(a);
    test_reset();
    test_reset_mid_drain();
    test_load_miss();
    test_forwarding();
    test_full_buffer();
    test_read_priority();
    test_pointer_wrap();
    test_store_with_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
